// File: rtl/saber_matvec_scheduler.sv
// Sequences a 256-coefficient polynomial multiplier across an LxL matrix-vector product.
// It owns the shared BRAM port for the whole job and writes one result row per matrix row.
module saber_matvec_scheduler #(
    parameter int L        = 3,
    parameter int AW       = 10,
    parameter int MAT_BASE = 0,
    parameter int SEC_BASE = 576,
    parameter int RES_BASE = 768,
    parameter int WDOG     = 4095
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          transpose,
    input  logic          coeff16,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mul_rst,
    output logic          mul_acc_clear,
    output logic          mul_read,
    output logic          mul_coeff4x,
    input  logic          mul_done,
    input  logic          mul_s_now,
    input  logic [6:0]    mul_a_addr,
    input  logic [7:0]    mul_s_addr,
    input  logic [63:0]   mul_coeff4x_out,
    output logic [AW-1:0] bram_addr,
    output logic          bram_we,
    output logic [63:0]   bram_wdata
);

    localparam int IW = (L > 1) ? $clog2(L) : 1;
    localparam int CW = $clog2(WDOG + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_MRST, S_RUN, S_NEXT, S_DRAIN, S_ROWNEXT, S_DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] i_idx;
    logic [IW-1:0] j_idx;
    logic [5:0]    k_idx;
    logic [CW-1:0] wd_cnt;
    logic          transpose_q;
    logic          coeff16_q;

    logic [AW-1:0] i_w;
    logic [AW-1:0] j_w;
    logic [AW-1:0] mat_poly;
    logic [AW-1:0] mat_addr;
    logic [AW-1:0] sec_addr;
    logic [AW-1:0] res_addr;

    // All index arithmetic is done at AW bits so overflow wraps inside the BRAM space.
    assign i_w      = AW'(i_idx);
    assign j_w      = AW'(j_idx);
    assign mat_poly = transpose_q ? (j_w * AW'(L) + i_w) : (i_w * AW'(L) + j_w);
    assign mat_addr = AW'(MAT_BASE) + mat_poly * AW'(64) + AW'(mul_a_addr);
    assign sec_addr = AW'(SEC_BASE) + j_w * AW'(64) + AW'(mul_s_addr);
    assign res_addr = AW'(RES_BASE) + i_w * AW'(64) + AW'(k_idx);

    assign mul_coeff4x = coeff16_q;
    assign bram_wdata  = mul_coeff4x_out;

    // NOTE: the default assignment ahead of the case keeps this block free of inferred latches.
    always_comb begin
        bram_addr = '0;
        case (state)
            S_RUN:   bram_addr = mul_s_now ? sec_addr : mat_addr;
            S_DRAIN: bram_addr = res_addr;
            default: bram_addr = '0;
        endcase
    end

    // NOTE: every register here is assigned with <=, so all branches see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            i_idx         <= '0;
            j_idx         <= '0;
            k_idx         <= '0;
            wd_cnt        <= '0;
            transpose_q   <= 1'b0;
            coeff16_q     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            mul_rst       <= 1'b1;
            mul_acc_clear <= 1'b0;
            mul_read      <= 1'b0;
            bram_we       <= 1'b0;
        end else begin
            done          <= 1'b0;
            err           <= 1'b0;
            mul_acc_clear <= 1'b0;
            case (state)
                S_IDLE: begin
                    mul_rst <= 1'b1;
                    if (start) begin
                        transpose_q   <= transpose;
                        coeff16_q     <= coeff16;
                        i_idx         <= '0;
                        j_idx         <= '0;
                        busy          <= 1'b1;
                        mul_acc_clear <= 1'b1;
                        state         <= S_CLR;
                    end
                end
                S_CLR: state <= S_MRST;
                S_MRST: begin
                    wd_cnt  <= '0;
                    mul_rst <= 1'b0;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    if (mul_done) begin
                        mul_rst <= 1'b1;
                        state   <= S_NEXT;
                    end else if (wd_cnt == CW'(WDOG)) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        mul_rst <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                S_NEXT: begin
                    if (j_idx != IW'(L - 1)) begin
                        j_idx <= j_idx + IW'(1);
                        state <= S_MRST;
                    end else begin
                        j_idx    <= '0;
                        k_idx    <= '0;
                        bram_we  <= 1'b1;
                        mul_read <= 1'b1;
                        state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Word k is written this cycle; the rotation lands for word k+1.
                    k_idx <= k_idx + 6'd1;
                    if (k_idx == 6'd63) begin
                        bram_we  <= 1'b0;
                        mul_read <= 1'b0;
                        state    <= S_ROWNEXT;
                    end
                end
                S_ROWNEXT: begin
                    if (i_idx != IW'(L - 1)) begin
                        i_idx         <= i_idx + IW'(1);
                        mul_acc_clear <= 1'b1;
                        state         <= S_CLR;
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_saber_matvec_scheduler.sv
// Directed bench for saber_matvec_scheduler: a behavioural negacyclic multiplier and
// a BRAM model sit around the scheduler and every result word is checked by value.
module tb_saber_matvec_scheduler;

    localparam int L        = 3;
    localparam int AW       = 10;
    localparam int MAT_BASE = 0;
    localparam int SEC_BASE = 576;
    localparam int RES_BASE = 768;
    localparam int WDOG     = 4095;
    localparam int T_MUL    = 129;
    localparam int JOB_LEN  = L * (L * (T_MUL + 2) + 1 + 64 + 1) + 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic          transpose;
    logic          coeff16;
    logic          busy;
    logic          done;
    logic          err;
    logic          mul_rst;
    logic          mul_acc_clear;
    logic          mul_read;
    logic          mul_coeff4x;
    logic          mul_done;
    logic          mul_s_now;
    logic [6:0]    mul_a_addr;
    logic [7:0]    mul_s_addr;
    logic [63:0]   mul_coeff4x_out;
    logic [AW-1:0] bram_addr;
    logic          bram_we;
    logic [63:0]   bram_wdata;

    saber_matvec_scheduler #(
        .L(L), .AW(AW), .MAT_BASE(MAT_BASE), .SEC_BASE(SEC_BASE),
        .RES_BASE(RES_BASE), .WDOG(WDOG)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .transpose(transpose), .coeff16(coeff16),
        .busy(busy), .done(done), .err(err), .mul_rst(mul_rst),
        .mul_acc_clear(mul_acc_clear), .mul_read(mul_read), .mul_coeff4x(mul_coeff4x),
        .mul_done(mul_done), .mul_s_now(mul_s_now), .mul_a_addr(mul_a_addr),
        .mul_s_addr(mul_s_addr), .mul_coeff4x_out(mul_coeff4x_out),
        .bram_addr(bram_addr), .bram_we(bram_we), .bram_wdata(bram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] src_mem [0:1023];
    logic [63:0] res_mem [0:1023];
    int          res_gen [0:1023];
    int          job_id;
    int          n_checks;
    int          n_errors;

    // Multiplier model: 64 s words, 64 A words, then one product cycle with mul_done.
    int          cyc;
    logic        hold_off;
    logic [12:0] acc [0:255];
    logic [12:0] sv  [0:255];
    logic [12:0] av  [0:255];

    assign mul_s_now       = (cyc < 64);
    assign mul_s_addr      = 8'(cyc);
    assign mul_a_addr      = 7'(cyc - 64);
    assign mul_done        = !hold_off && !mul_rst && (cyc == 128);
    assign mul_coeff4x_out = {3'b0, acc[3], 3'b0, acc[2], 3'b0, acc[1], 3'b0, acc[0]};

    always @(posedge clk) begin : mul_model
        logic [12:0] prod [0:255];
        logic [63:0] w;
        if (mul_rst) begin
            cyc <= 0;
        end else if (cyc < 128) begin
            w = src_mem[bram_addr];
            for (int t = 0; t < 4; t++) begin
                if (cyc < 64) sv[cyc * 4 + t] <= w[16 * t +: 13];
                else          av[(cyc - 64) * 4 + t] <= w[16 * t +: 13];
            end
            cyc <= cyc + 1;
        end else if (mul_done) begin
            cyc <= 129;
        end
        if (mul_acc_clear) begin
            for (int n = 0; n < 256; n++) acc[n] <= 13'd0;
        end else if (mul_read) begin
            for (int n = 0; n < 256; n++) acc[n] <= acc[(n + 4) % 256];
        end else if (mul_done) begin
            for (int n = 0; n < 256; n++) prod[n] = 13'd0;
            for (int a = 0; a < 256; a++) begin
                for (int b = 0; b < 256; b++) begin
                    if (a + b < 256) prod[a + b]       = prod[a + b] + av[a] * sv[b];
                    else             prod[a + b - 256] = prod[a + b - 256] - av[a] * sv[b];
                end
            end
            for (int n = 0; n < 256; n++) acc[n] <= acc[n] + prod[n];
        end
    end

    int n_writes, n_oob, n_done, n_err, n_busy, n_run, n_viol;
    initial begin
        n_writes = 0; n_oob = 0; n_done = 0; n_err = 0; n_busy = 0; n_run = 0; n_viol = 0;
    end

    always @(posedge clk) begin : monitor
        if (bram_we) begin
            res_mem[bram_addr] <= bram_wdata;
            res_gen[bram_addr] <= job_id;
            n_writes <= n_writes + 1;
            if (bram_addr < AW'(RES_BASE) || bram_addr > AW'(RES_BASE + L * 64 - 1))
                n_oob <= n_oob + 1;
        end
        if (done)               n_done <= n_done + 1;
        if (err)                n_err  <= n_err + 1;
        if (busy)               n_busy <= n_busy + 1;
        if (!mul_rst)           n_run  <= n_run + 1;
        if (mul_read && !mul_rst) n_viol <= n_viol + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // kind: 0 zero, 1 constant one, 2 ramp 0..255, 3 all fives
    task automatic load_poly(input int base, input int kind);
        logic [63:0] word;
        int c;
        for (int w = 0; w < 64; w++) begin
            for (int t = 0; t < 4; t++) begin
                c = 4 * w + t;
                case (kind)
                    1:       word[16 * t +: 16] = (c == 0) ? 16'd1 : 16'd0;
                    2:       word[16 * t +: 16] = 16'(c);
                    3:       word[16 * t +: 16] = 16'd5;
                    default: word[16 * t +: 16] = 16'd0;
                endcase
            end
            src_mem[base + w] = word;
        end
    endtask

    task automatic check_row(input int row, input int mult);
        logic [63:0] exp;
        logic [63:0] obs;
        int a;
        for (int w = 0; w < 64; w++) begin
            for (int t = 0; t < 4; t++) exp[16 * t +: 16] = 16'((mult * (4 * w + t)) % 8192);
            a   = RES_BASE + row * 64 + w;
            obs = (res_gen[a] == job_id) ? res_mem[a] : 64'hDEAD_DEAD_DEAD_DEAD;
            check($sformatf("job%0d row%0d word%0d", job_id, row, w), obs, exp);
        end
    endtask

    task automatic pulse_start(input logic tr);
        start     = 1'b1;
        transpose = tr;
        coeff16   = 1'b1;
        tick(1);
        start     = 1'b0;
        transpose = 1'b0;
        coeff16   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (!done && c < 3000) begin
            tick(1);
            c++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    // Full job with length and write-range checks; rows are checked by the caller.
    task automatic run_job(input logic tr, input string tag);
        int b0, w0, o0;
        job_id++;
        b0 = n_busy; w0 = n_writes; o0 = n_oob;
        pulse_start(tr);
        wait_done({tag, " done"});
        tick(2);
        check({tag, " job length"}, 64'(n_busy - b0), 64'(JOB_LEN));
        check({tag, " write count"}, 64'(n_writes - w0), 64'(L * 64));
        check({tag, " writes outside result"}, 64'(n_oob - o0), 64'd0);
        check({tag, " busy after"}, 64'(busy), 64'd0);
    endtask

    initial begin : stim
        int d0, e0, r0, w0, c;
        n_checks = 0; n_errors = 0; job_id = 0;
        rst = 1'b1; start = 1'b0; transpose = 1'b0; coeff16 = 1'b0; hold_off = 1'b0;
        for (int n = 0; n < 1024; n++) begin
            src_mem[n] = 64'd0;
            res_mem[n] = 64'd0;
            res_gen[n] = 0;
        end

        tick(3);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset err", 64'(err), 64'd0);
        check("reset mul_rst", 64'(mul_rst), 64'd1);
        check("reset mul_acc_clear", 64'(mul_acc_clear), 64'd0);
        check("reset mul_read", 64'(mul_read), 64'd0);
        check("reset bram_we", 64'(bram_we), 64'd0);
        check("reset bram_addr", 64'(bram_addr), 64'd0);
        rst = 1'b0;
        tick(2);

        // A[0][0]=1 only; s0 ramp, s1/s2 fives so a wrong s index shows up.
        for (int p = 0; p < L * L; p++) load_poly(MAT_BASE + p * 64, (p == 0) ? 1 : 0);
        load_poly(SEC_BASE, 2);
        load_poly(SEC_BASE + 64, 3);
        load_poly(SEC_BASE + 128, 3);
        run_job(1'b0, "direct");
        check("coeff4x latched", 64'(mul_coeff4x), 64'd1);
        check_row(0, 1);
        check_row(1, 0);
        check_row(2, 0);

        // Only A[0][1]=1 under transpose: lands in row 1.
        for (int p = 0; p < L * L; p++) load_poly(MAT_BASE + p * 64, (p == 1) ? 1 : 0);
        run_job(1'b1, "transpose");
        check_row(0, 0);
        check_row(1, 1);
        check_row(2, 0);

        // All A = 1, all s = ramp: every row is 3*ramp.
        for (int p = 0; p < L * L; p++) load_poly(MAT_BASE + p * 64, 1);
        for (int p = 0; p < L; p++) load_poly(SEC_BASE + p * 64, 2);
        run_job(1'b0, "full");
        check_row(0, 3);
        check_row(1, 3);
        check_row(2, 3);

        // Second start while running is ignored.
        job_id++;
        d0 = n_done;
        pulse_start(1'b0);
        tick(20);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done("restart done");
        tick(40);
        check("restart done count", 64'(n_done - d0), 64'd1);
        check("restart busy after", 64'(busy), 64'd0);
        check_row(1, 3);

        // Synchronous reset during row 1, then a clean job.
        job_id++;
        w0 = n_writes;
        pulse_start(1'b0);
        c = 0;
        while (n_writes - w0 < 64 && c < 1000) begin
            tick(1);
            c++;
        end
        check("row0 drained before reset", 64'(n_writes - w0), 64'd64);
        tick(10);
        rst = 1'b1;
        tick(1);
        check("mid reset busy", 64'(busy), 64'd0);
        check("mid reset mul_rst", 64'(mul_rst), 64'd1);
        check("mid reset bram_we", 64'(bram_we), 64'd0);
        rst = 1'b0;
        tick(1);
        run_job(1'b0, "after reset");
        check_row(0, 3);
        check_row(2, 3);

        // Multiplier never finishes: watchdog abort.
        hold_off = 1'b1;
        d0 = n_done; e0 = n_err; r0 = n_run;
        pulse_start(1'b0);
        c = 0;
        while (!err && c < 5000) begin
            tick(1);
            c++;
        end
        check("watchdog err", 64'(err), 64'd1);
        check("watchdog run cycles", 64'(n_run - r0), 64'(WDOG + 1));
        check("watchdog busy", 64'(busy), 64'd0);
        check("watchdog mul_rst", 64'(mul_rst), 64'd1);
        tick(1);
        check("watchdog err pulse width", 64'(err), 64'd0);
        tick(5);
        check("watchdog err count", 64'(n_err - e0), 64'd1);
        check("watchdog no done", 64'(n_done - d0), 64'd0);
        hold_off = 1'b0;

        check("mul_read with mul_rst low", 64'(n_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
